// File: rtl/aes_pkg.sv
// Shared AES key-schedule definitions: mode encodings, Nk/Nr lookup,
// GF(2^8) doubling and the forward S-box.
package aes_pkg;

   typedef enum logic [1:0] {
      MODE_128 = 2'd0,
      MODE_192 = 2'd1,
      MODE_256 = 2'd2,
      MODE_INV = 2'd3
   } mode_e;

   typedef enum logic {
      ST_IDLE   = 1'b0,
      ST_EXPAND = 1'b1
   } state_e;

   function automatic logic [3:0] mode_nk(input logic [1:0] m);
      case (m)
         MODE_128: mode_nk = 4'd4;
         MODE_192: mode_nk = 4'd6;
         MODE_256: mode_nk = 4'd8;
         default:  mode_nk = 4'd0;
      endcase
   endfunction

   function automatic logic [3:0] mode_nr(input logic [1:0] m);
      case (m)
         MODE_128: mode_nr = 4'd10;
         MODE_192: mode_nr = 4'd12;
         MODE_256: mode_nr = 4'd14;
         default:  mode_nr = 4'd0;
      endcase
   endfunction

   function automatic logic [7:0] xtime(input logic [7:0] b);
      xtime = {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   localparam logic [7:0] SBOX [256] = '{
      8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
      8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
      8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
      8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
      8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
      8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
      8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
      8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
      8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
      8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
      8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
      8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
      8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
      8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
      8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
      8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
   };

endpackage

// File: rtl/aes_subword.sv
// SubWord: four parallel S-box lookups on one 32-bit schedule word.
module aes_subword
   import aes_pkg::*;
(
   input  logic [31:0] i_word,
   output logic [31:0] o_word
);

   assign o_word = {SBOX[i_word[31:24]], SBOX[i_word[23:16]],
                    SBOX[i_word[15:8]],  SBOX[i_word[7:0]]};

endmodule

// File: rtl/aes_key_scheduler.sv
// Sequential AES-128/192/256 key expansion, one schedule word per clock,
// into a round-key store read out four words at a time.
//
// state     | meaning
// ST_IDLE   | ready; key words loaded on start, invalid mode pulses err
// ST_EXPAND | generating w[i] each cycle until word 4*(Nr+1)-1 is written
module aes_key_scheduler
   import aes_pkg::*;
#(
   parameter int MAX_NK = 8,
   parameter int RK_W   = 128
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                start,
   input  logic [1:0]          mode,
   input  logic [32*MAX_NK-1:0] key_in,
   output logic                ready,
   output logic                busy,
   output logic                done,
   output logic                key_valid,
   output logic                err,
   input  logic [3:0]          rk_sel,
   output logic [RK_W-1:0]     rk_out
);

   localparam int DEPTH = 4 * (MAX_NK + 7);
   localparam int KW    = 32 * MAX_NK;

   state_e      r_state;
   state_e      w_state_nxt;
   logic [31:0] r_store [DEPTH];
   logic [3:0]  r_nk;
   logic [3:0]  r_nr;
   logic [5:0]  r_i;
   logic [5:0]  r_last;
   logic [2:0]  r_j;
   logic [7:0]  r_rcon;
   logic        r_done;
   logic        r_err;
   logic        r_key_valid;

   logic        w_accept;
   logic        w_reject;
   logic        w_last;
   logic [3:0]  w_nk;
   logic [3:0]  w_nr;
   logic        w_mode_ok;
   logic [31:0] w_prev;
   logic [31:0] w_back;
   logic [31:0] w_sub_in;
   logic [31:0] w_sub_out;
   logic [31:0] w_t;
   logic [31:0] w_new;
   logic [2:0]  w_j_nxt;
   logic [3:0]  w_rk_idx;
   logic [5:0]  w_rk_base;

   assign w_nk      = mode_nk(mode);
   assign w_nr      = mode_nr(mode);
   assign w_mode_ok = (mode != MODE_INV) && (w_nk <= 4'(MAX_NK));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= ST_IDLE;
      else        r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      w_accept    = 1'b0;
      w_reject    = 1'b0;
      w_last      = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (start) begin
               if (w_mode_ok) begin
                  w_accept    = 1'b1;
                  w_state_nxt = ST_EXPAND;
               end else begin
                  w_reject    = 1'b1;
               end
            end
         end
         ST_EXPAND: begin
            if (r_i == r_last) begin
               w_last      = 1'b1;
               w_state_nxt = ST_IDLE;
            end
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   assign busy      = (r_state == ST_EXPAND);
   assign ready     = ~busy;
   assign done      = r_done;
   assign err       = r_err;
   assign key_valid = r_key_valid;

   // RotWord is folded into the operand so one SubWord serves both j==0 and j==4.
   assign w_prev   = r_store[r_i - 6'd1];
   assign w_back   = r_store[r_i - {2'b00, r_nk}];
   assign w_sub_in = (r_j == 3'd0) ? {w_prev[23:0], w_prev[31:24]} : w_prev;

   aes_subword u_subword (
      .i_word (w_sub_in),
      .o_word (w_sub_out)
   );

   always_comb begin
      w_t = w_prev;
      if (r_j == 3'd0)
         w_t = w_sub_out ^ {r_rcon, 24'h000000};
      else if ((r_nk == 4'd8) && (r_j == 3'd4))
         w_t = w_sub_out;
   end

   assign w_new   = w_back ^ w_t;
   assign w_j_nxt = ({1'b0, r_j} == (r_nk - 4'd1)) ? 3'd0 : (r_j + 3'd1);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < DEPTH; k++) r_store[k] <= '0;
         r_nk        <= '0;
         r_nr        <= '0;
         r_i         <= '0;
         r_last      <= '0;
         r_j         <= '0;
         r_rcon      <= '0;
         r_done      <= 1'b0;
         r_err       <= 1'b0;
         r_key_valid <= 1'b0;
      end else begin
         r_done <= w_last;
         r_err  <= w_reject;
         if (w_accept) begin
            for (int k = 0; k < MAX_NK; k++)
               if (4'(k) < w_nk) r_store[k] <= key_in[KW-1-32*k -: 32];
            r_nk        <= w_nk;
            r_nr        <= w_nr;
            r_last      <= {w_nr, 2'b11};
            r_i         <= {2'b00, w_nk};
            r_j         <= 3'd0;
            r_rcon      <= 8'h01;
            r_key_valid <= 1'b0;
         end else if (r_state == ST_EXPAND) begin
            r_store[r_i] <= w_new;
            r_i          <= r_i + 6'd1;
            r_j          <= w_j_nxt;
            if (r_j == 3'd0) r_rcon <= xtime(r_rcon);
            if (w_last)      r_key_valid <= 1'b1;
         end
      end
   end

   // Out-of-range selects read entry 0 and are then forced to zero.
   assign w_rk_idx  = (rk_sel > r_nr) ? 4'd0 : rk_sel;
   assign w_rk_base = {w_rk_idx, 2'b00};
   assign rk_out    = (rk_sel > r_nr) ? '0 :
                      {r_store[w_rk_base],         r_store[w_rk_base + 6'd1],
                       r_store[w_rk_base + 6'd2],  r_store[w_rk_base + 6'd3]};

endmodule

// File: tb/tb_aes_key_scheduler.sv
// Self-checking bench for aes_key_scheduler: known-answer table, corner
// sequences and random keys against an arithmetic AES key-schedule model.
module tb_aes_key_scheduler;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         start;
   logic [1:0]   mode;
   logic [255:0] key_in;
   logic         ready, busy, done, key_valid, err;
   logic [3:0]   rk_sel;
   logic [127:0] rk_out;

   int n_cmp  = 0;
   int n_fail = 0;

   aes_key_scheduler #(.MAX_NK(8), .RK_W(128)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .mode      (mode),
      .key_in    (key_in),
      .ready     (ready),
      .busy      (busy),
      .done      (done),
      .key_valid (key_valid),
      .err       (err),
      .rk_sel    (rk_sel),
      .rk_out    (rk_out)
   );

   always #5 clk = ~clk;

   localparam logic [127:0] K128 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
   localparam logic [191:0] K192 = 192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b;
   localparam logic [255:0] K256 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
   localparam logic [127:0] RK128_10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
   localparam logic [127:0] RK192_12 = 128'he98ba06f448c773c8ecc720401002202;
   localparam logic [127:0] RK256_14 = 128'hfe4890d1e6188d0b046df344706c631e;

   typedef struct {
      logic [1:0]   mode;
      logic [255:0] key;
      logic [3:0]   sel;
      logic [127:0] exp_rk;
      int           exp_cyc;
   } vec_t;

   vec_t vecs [5];

   // ---------------- reference model (GF(2^8) arithmetic) ----------------
   logic [7:0]  m_sbox [256];
   logic [31:0] m_w [60];
   int          m_nr;

   function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p = 8'h00;
      for (int n = 0; n < 8; n++) begin
         if (b[0]) p ^= a;
         a = a[7] ? ({a[6:0], 1'b0} ^ 8'h1b) : {a[6:0], 1'b0};
         b = b >> 1;
      end
      return p;
   endfunction

   function automatic logic [7:0] rotl8(input logic [7:0] v, input int s);
      return (v << s) | (v >> (8 - s));
   endfunction

   task automatic build_sbox();
      for (int a = 0; a < 256; a++) begin
         logic [7:0] inv = 8'h00;
         for (int b = 1; b < 256; b++)
            if (gf_mul(8'(a), 8'(b)) == 8'h01) inv = 8'(b);
         m_sbox[a] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
      end
   endtask

   function automatic logic [31:0] sub_word(input logic [31:0] v);
      return {m_sbox[v[31:24]], m_sbox[v[23:16]], m_sbox[v[15:8]], m_sbox[v[7:0]]};
   endfunction

   task automatic model_expand(input int md, input logic [255:0] key);
      int nk = 4 + 2 * md;
      logic [7:0] rc = 8'h01;
      logic [31:0] t;
      m_nr = nk + 6;
      for (int i = 0; i < 60; i++) m_w[i] = 32'h0;
      for (int i = 0; i < nk; i++) m_w[i] = key[255 - 32*i -: 32];
      for (int i = nk; i < 4 * (m_nr + 1); i++) begin
         t = m_w[i-1];
         if (i % nk == 0) begin
            t  = sub_word({t[23:0], t[31:24]}) ^ {rc, 24'h0};
            rc = gf_mul(rc, 8'h02);
         end else if (nk > 6 && i % nk == 4) begin
            t = sub_word(t);
         end
         m_w[i] = m_w[i-nk] ^ t;
      end
   endtask

   function automatic logic [127:0] model_rk(input int s);
      if (s > m_nr) return 128'h0;
      return {m_w[4*s], m_w[4*s+1], m_w[4*s+2], m_w[4*s+3]};
   endfunction

   // ---------------- helpers ----------------
   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic wait_done(output int cyc);
      cyc = 0;
      while (!done && cyc < 200) begin
         @(posedge clk); #1;
         cyc++;
      end
   endtask

   // Called 1 time unit after an edge; returns with done visible.
   task automatic run(input logic [1:0] md, input logic [255:0] key, output int cyc);
      mode = md; key_in = key; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      check("busy_after_accept", 128'(busy), 128'(1));
      wait_done(cyc);
   endtask

   task automatic check_outputs_reset(input string tag);
      check({tag, "_ready"},     128'(ready),     128'(1));
      check({tag, "_busy"},      128'(busy),      128'(0));
      check({tag, "_done"},      128'(done),      128'(0));
      check({tag, "_key_valid"}, 128'(key_valid), 128'(0));
      check({tag, "_err"},       128'(err),       128'(0));
      check({tag, "_rk_out"},    rk_out,          128'h0);
   endtask

   initial begin
      int cyc;
      int md;
      logic [255:0] rkey;

      rst_n = 1'b0; start = 1'b0; mode = 2'd0; key_in = '0; rk_sel = 4'd0;
      build_sbox();

      vecs[0] = '{2'd0, {K128, 128'h0}, 4'd10, RK128_10,   40};
      vecs[1] = '{2'd0, {K128, 128'h0}, 4'd0,  K128,       40};
      vecs[2] = '{2'd0, {K128, 128'h0}, 4'd11, 128'h0,     40};
      vecs[3] = '{2'd1, {K192, 64'h0},  4'd12, RK192_12,   46};
      vecs[4] = '{2'd2, K256,           4'd14, RK256_14,   52};

      #12;
      check_outputs_reset("reset");
      rst_n = 1'b1;
      @(posedge clk); #1;

      // Known-answer table
      foreach (vecs[v]) begin
         run(vecs[v].mode, vecs[v].key, cyc);
         check("kat_cycles", 128'(cyc), 128'(vecs[v].exp_cyc));
         check("kat_key_valid", 128'(key_valid), 128'(1));
         rk_sel = vecs[v].sel; #1;
         check("kat_rk_out", rk_out, vecs[v].exp_rk);
         @(posedge clk); #1;
         check("kat_done_pulse", 128'(done), 128'(0));
      end

      // start held high throughout an AES-128 run, then a back-to-back restart
      mode = 2'd0; key_in = {K128, 128'h0}; start = 1'b1;
      @(posedge clk); #1;
      wait_done(cyc);
      check("spam_cycles", 128'(cyc), 128'(40));
      @(posedge clk); #1;
      check("restart_busy", 128'(busy), 128'(1));
      check("restart_key_valid", 128'(key_valid), 128'(0));
      start = 1'b0;
      wait_done(cyc);
      check("restart_cycles", 128'(cyc), 128'(40));
      rk_sel = 4'd10; #1;
      check("restart_rk10", rk_out, RK128_10);
      @(posedge clk); #1;

      // Invalid mode
      mode = 2'd3; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      check("inv_err", 128'(err), 128'(1));
      check("inv_ready", 128'(ready), 128'(1));
      check("inv_key_valid", 128'(key_valid), 128'(1));
      check("inv_rk_keep", rk_out, RK128_10);
      @(posedge clk); #1;
      check("inv_err_pulse", 128'(err), 128'(0));

      // Reset in the middle of an AES-256 expansion
      mode = 2'd2; key_in = K256; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (20) @(posedge clk);
      #1 rst_n = 1'b0;
      rk_sel = 4'd0;
      #1;
      check_outputs_reset("midrst");
      rk_sel = 4'd14; #1;
      check("midrst_rk14", rk_out, 128'h0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      run(2'd0, {K128, 128'h0}, cyc);
      check("rerun_cycles", 128'(cyc), 128'(40));
      rk_sel = 4'd10; #1;
      check("rerun_rk10", rk_out, RK128_10);
      @(posedge clk); #1;

      // Random keys and modes against the model
      for (int r = 0; r < 6; r++) begin
         md   = $urandom_range(0, 2);
         rkey = {$urandom(), $urandom(), $urandom(), $urandom(),
                 $urandom(), $urandom(), $urandom(), $urandom()};
         model_expand(md, rkey);
         run(2'(md), rkey, cyc);
         check("rnd_cycles", 128'(cyc), 128'(4 * (m_nr + 1) - (4 + 2 * md)));
         check("rnd_key_valid", 128'(key_valid), 128'(1));
         for (int s = 0; s < 16; s++) begin
            rk_sel = 4'(s); #1;
            check("rnd_rk_out", rk_out, model_rk(s));
         end
         @(posedge clk); #1;
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/aes_key_scheduler.md
# aes_key_scheduler

Sequential AES key-schedule engine for AES-128, AES-192 and AES-256, with the key length selectable per operation. It expands the cipher key at one 32-bit schedule word per clock into an internal round-key store. The store is then served to the cipher round datapath through a random-access round-key read port. It replaces per-round combinational expansion stages with one shared word generator and a 60-word buffer.

## Interface
Parameters:
- MAX_NK, 8, largest key length in words; fixes store depth at 4*(MAX_NK+7) = 60 words; legal values 4, 6, 8 (modes above MAX_NK are rejected as invalid)
- RK_W, 128, round-key output width; fixed at 4 words

Ports (one clock; reset is asynchronous and active-low):
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  request to expand key_in; accepted when start & ready
- mode  in  2  0 = AES-128 (Nk=4, Nr=10), 1 = AES-192 (Nk=6, Nr=12), 2 = AES-256 (Nk=8, Nr=14), 3 = invalid
- key_in  in  32*MAX_NK  cipher key, MSB-aligned; word0 = key_in[top 32 bits]; unused low bits ignored
- ready  out  1  idle, can accept start
- busy  out  1  expansion in progress
- done  out  1  one-cycle pulse on completion
- key_valid  out  1  store holds a complete schedule for the last accepted mode
- err  out  1  one-cycle pulse when start is presented with an invalid mode
- rk_sel  in  4  round index 0..Nr
- rk_out  out  RK_W  {w[4r], w[4r+1], w[4r+2], w[4r+3]}, w[4r] in MSBs

## Operation
- FSM has two states, IDLE and EXPAND. Reset enters IDLE.
- IDLE, start=1, valid mode:
  - latch Nk and Nr; write key words 0..Nk-1 into the store
  - set word index i=Nk, phase counter j=0, rcon=0x01
  - clear key_valid; go to EXPAND
- IDLE, start=1, invalid mode (3, or Nk > MAX_NK): pulse err; stay in IDLE; store and key_valid unchanged.
- EXPAND: each cycle computes w[i] = w[i-Nk] ^ t, where t is:
  - j==0: SubWord(RotWord(w[i-1])) ^ {rcon, 24'h0}; after use, rcon <= xtime(rcon), so 0x80 becomes 0x1B
  - Nk==8 and j==4: SubWord(w[i-1])
  - otherwise: w[i-1]
- Phase counter j wraps Nk-1 -> 0. No divide or modulo hardware.
- Total words written: 4*(Nr+1) = 44, 52 or 60. When the last word is written, go to IDLE, pulse done and set key_valid.
- start during EXPAND is ignored (ready=0). It is not queued.
- rk_out is combinational from the store.
  - Returns 0 when rk_sel > Nr of the latched mode.
  - Is undefined-but-stable (current store contents) while key_valid=0.

## Timing
- Reset values: ready=1, busy=0, done=0, key_valid=0, err=0; store, i, j and rcon cleared, so rk_out=0.
- ready = ~busy, combinational from state.
- Accept edge E0 writes key words and raises busy. Word w[Nk+k] is written at edge E(k+1).
- Expansion cycles after E0: 40 (AES-128), 46 (AES-192), 52 (AES-256).
  - done and key_valid rise, and busy falls, at the edge that writes the last word.
  - A new start is accepted at the next edge at the earliest.
- err is registered, high the cycle after the rejected start.
- rk_out changes in the same cycle as rk_sel (zero latency). The cipher registers it.
- Reset asserted mid-expansion: immediate return to reset values; no partial key_valid.

## Structure
Shared package `aes_pkg`:
- mode encodings and the Nk/Nr lookup
- xtime function
- S-box table constant

Sub-module `aes_subword`: combinational, four S-box lookups on one 32-bit word. It is instantiated once and shared by the j==0 path and the AES-256 j==4 path via an operand mux. Its only operand is w[i-1], so RotWord is applied before the mux. The FSM, counters, rcon register and store live in the top module.

## Test plan
- AES-128, key 2b7e151628aed2a6abf7158809cf4f3c -> done exactly 40 cycles after accept; rk_sel=10 gives d014f9a8c9ee2589e13f0cc8b6630ca6; rk_sel=0 echoes the key; rk_sel=11 gives 0.
- AES-192, key 8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b -> done after 46 cycles; rk_sel=12 gives e98ba06f448c773c8ecc720401002202.
- AES-256, key 603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4 -> done after 52 cycles; rk_sel=14 gives fe4890d1e6188d0b046df344706c631e.
- Start pulsed every cycle during an AES-128 run -> ignored; single done; results identical to the clean run. A second start on the cycle after done is accepted.
- mode=3 with start -> err high one cycle; ready stays 1; key_valid and rk_out keep the prior schedule.
- rst_n low at cycle 20 of AES-256 -> all outputs at reset values at once. Rerun with the AES-128 vector -> correct round 10 key.
